// File: rtl/hough_ctrl_pkg.sv
// Shared types and constants for the Hough lane-detection sequencer:
// state encoding, phase-vector widths and a parameter helper.
package hough_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_PIX,
    ST_V0,
    ST_V1,
    ST_V2,
    ST_V3,
    ST_PUSH,
    ST_POP,
    ST_SETUP,
    ST_CALC,
    ST_WR,
    ST_DONE
  } state_e;

  localparam int unsigned VOTE_PH_W  = 4;
  localparam int unsigned SETUP_PH_W = 3;
  localparam int unsigned PEAK_SEL_W = 2;

  // Number of LANES-wide groups needed to cover n items.
  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/hough_loop_cnt.sv
// Up-counter with programmable step; 'last' flags that one more step
// would reach or pass LIMIT. clr has priority over inc.
module hough_loop_cnt #(
  parameter int unsigned W     = 8,
  parameter int unsigned STEP  = 1,
  parameter int unsigned LIMIT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (W+1)'(STEP);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = sum[W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (32'(sum) >= LIMIT);

endmodule

// File: rtl/hough_seq_ctrl.sv
// Sequencer for the Hough datapath: per-pixel theta vote sweep, peak push,
// then per-peak line setup and J_LIMIT-point draw loop.
module hough_seq_ctrl
  import hough_ctrl_pkg::*;
#(
  parameter int unsigned N_THETA = 180,
  parameter int unsigned LANES   = 2,
  parameter int unsigned J_LIMIT = 1000,
  parameter int unsigned N_PEAKS = 2,
  parameter int unsigned THETA_W = 8,
  parameter int unsigned J_W     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic                  pix_last,
  output logic                  acc_clr,
  output logic [VOTE_PH_W-1:0]  vote_ph,
  output logic [THETA_W-1:0]    theta_base,
  output logic [LANES-1:0]      lane_en,
  output logic                  vote_we,
  output logic                  q_push,
  output logic [PEAK_SEL_W-1:0] peak_sel,
  input  logic                  q_empty,
  output logic                  q_pop,
  output logic [SETUP_PH_W-1:0] setup_ph,
  output logic [J_W-1:0]        j,
  output logic                  draw_we,
  output logic                  busy,
  output logic                  done
);

  state_e     state_q, state_d;
  logic       last_pix_q, last_pix_d;
  logic [1:0] setup_cnt_q, setup_cnt_d;
  logic       acc_clr_q, acc_clr_d;
  logic       q_pop_q, q_pop_d;

  logic                  theta_clr, theta_inc, theta_last;
  logic                  peak_clr, peak_inc, peak_last;
  logic                  j_clr, j_inc, j_last;
  logic [THETA_W-1:0]    theta_cnt;
  logic [PEAK_SEL_W-1:0] peak_cnt;
  logic [J_W-1:0]        j_cnt;
  logic                  in_vote;

  hough_loop_cnt #(.W(THETA_W), .STEP(LANES), .LIMIT(N_THETA)) u_theta_cnt (
    .clk(clk), .reset(reset), .clr(theta_clr), .inc(theta_inc),
    .cnt(theta_cnt), .last(theta_last)
  );

  hough_loop_cnt #(.W(PEAK_SEL_W), .STEP(1), .LIMIT(N_PEAKS)) u_peak_cnt (
    .clk(clk), .reset(reset), .clr(peak_clr), .inc(peak_inc),
    .cnt(peak_cnt), .last(peak_last)
  );

  hough_loop_cnt #(.W(J_W), .STEP(1), .LIMIT(J_LIMIT)) u_j_cnt (
    .clk(clk), .reset(reset), .clr(j_clr), .inc(j_inc),
    .cnt(j_cnt), .last(j_last)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    last_pix_d  = last_pix_q;
    setup_cnt_d = setup_cnt_q;
    acc_clr_d   = 1'b0;
    q_pop_d     = 1'b0;
    theta_clr   = 1'b0;
    theta_inc   = 1'b0;
    peak_clr    = 1'b0;
    peak_inc    = 1'b0;
    j_clr       = 1'b0;
    j_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_clr_d = 1'b1;
          theta_clr = 1'b1;
          state_d   = ST_WAIT_PIX;
        end
      end
      ST_WAIT_PIX: begin
        if (pix_valid) begin
          last_pix_d = pix_last;
          theta_clr  = 1'b1;
          state_d    = ST_V0;
        end
      end
      ST_V0: state_d = ST_V1;
      ST_V1: state_d = ST_V2;
      ST_V2: state_d = ST_V3;
      ST_V3: begin
        theta_inc = 1'b1;
        if (!theta_last) begin
          state_d = ST_V0;
        end else if (last_pix_q) begin
          peak_clr = 1'b1;
          state_d  = ST_PUSH;
        end else begin
          state_d = ST_WAIT_PIX;
        end
      end
      ST_PUSH: begin
        if (peak_last) begin
          state_d = ST_POP;
        end else begin
          peak_inc = 1'b1;
        end
      end
      ST_POP: begin
        // q_pop is registered, so the pop strobe lands in the first setup cycle.
        if (q_empty) begin
          state_d = ST_DONE;
        end else begin
          q_pop_d     = 1'b1;
          setup_cnt_d = 2'd0;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        j_clr = 1'b1;
        if (setup_cnt_q == 2'd2) begin
          setup_cnt_d = 2'd0;
          state_d     = ST_CALC;
        end else begin
          setup_cnt_d = setup_cnt_q + 2'd1;
        end
      end
      ST_CALC: state_d = ST_WR;
      ST_WR: begin
        if (j_last) begin
          state_d = ST_POP;
        end else begin
          j_inc   = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        theta_clr  = 1'b1;
        peak_clr   = 1'b1;
        j_clr      = 1'b1;
        last_pix_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything decoded above, including start and the stream.
    if (abort) begin
      state_d     = ST_IDLE;
      last_pix_d  = 1'b0;
      setup_cnt_d = 2'd0;
      acc_clr_d   = 1'b0;
      q_pop_d     = 1'b0;
      theta_clr   = 1'b1;
      theta_inc   = 1'b0;
      peak_clr    = 1'b1;
      peak_inc    = 1'b0;
      j_clr       = 1'b1;
      j_inc       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_pix_q  <= 1'b0;
      setup_cnt_q <= 2'd0;
      acc_clr_q   <= 1'b0;
      q_pop_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_pix_q  <= last_pix_d;
      setup_cnt_q <= setup_cnt_d;
      acc_clr_q   <= acc_clr_d;
      q_pop_q     <= q_pop_d;
    end
  end

  // Outputs depend only on flops, never directly on inputs.
  always_comb begin
    in_vote = (state_q == ST_V0) || (state_q == ST_V1) ||
              (state_q == ST_V2) || (state_q == ST_V3);
    unique case (state_q)
      ST_V0:   vote_ph = 4'b0001;
      ST_V1:   vote_ph = 4'b0010;
      ST_V2:   vote_ph = 4'b0100;
      ST_V3:   vote_ph = 4'b1000;
      default: vote_ph = 4'b0000;
    endcase
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_en[i] = in_vote && ((32'(theta_cnt) + i) < N_THETA);
    end
    pix_ready  = (state_q == ST_WAIT_PIX);
    acc_clr    = acc_clr_q;
    theta_base = theta_cnt;
    vote_we    = (state_q == ST_V3);
    q_push     = (state_q == ST_PUSH);
    peak_sel   = (state_q == ST_PUSH) ? peak_cnt : '0;
    q_pop      = q_pop_q;
    setup_ph   = (state_q == ST_SETUP) ? (3'b001 << setup_cnt_q) : 3'b000;
    j          = j_cnt;
    draw_we    = (state_q == ST_WR);
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_hough_seq_ctrl.sv
// Scoreboard bench: a small instance (N_THETA=7, J_LIMIT=4) for sequencing
// and control corners, plus a default instance for full vote latency.
module tb_hough_seq_ctrl;
  import hough_ctrl_pkg::*;

  typedef struct {
    logic [7:0] theta;
    logic [1:0] lane;
  } vote_exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Small instance
  logic       s_start, s_abort, s_pix_valid, s_pix_last, s_q_empty;
  logic       s_pix_ready, s_acc_clr, s_vote_we, s_q_push, s_q_pop;
  logic       s_draw_we, s_busy, s_done;
  logic [3:0] s_vote_ph;
  logic [7:0] s_theta_base;
  logic [1:0] s_lane_en, s_peak_sel;
  logic [2:0] s_setup_ph;
  logic [9:0] s_j;

  // Default instance
  logic       d_start, d_abort, d_pix_valid, d_pix_last, d_q_empty;
  logic       d_pix_ready, d_acc_clr, d_vote_we, d_q_push, d_q_pop;
  logic       d_draw_we, d_busy, d_done;
  logic [3:0] d_vote_ph;
  logic [7:0] d_theta_base;
  logic [1:0] d_lane_en, d_peak_sel;
  logic [2:0] d_setup_ph;
  logic [9:0] d_j;

  int n_checks = 0;
  int n_fail   = 0;
  int s_loaded = 0;
  int s_pops   = 0;
  int s_done_cnt = 0;
  logic s_acc = 1'b0;
  logic d_acc = 1'b0;

  vote_exp_t vote_q[$];
  int        push_q[$];
  int        draw_q[$];

  assign s_q_empty = (s_loaded == s_pops);

  hough_seq_ctrl #(.N_THETA(7), .LANES(2), .J_LIMIT(4), .N_PEAKS(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort),
    .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .pix_last(s_pix_last),
    .acc_clr(s_acc_clr), .vote_ph(s_vote_ph), .theta_base(s_theta_base),
    .lane_en(s_lane_en), .vote_we(s_vote_we), .q_push(s_q_push),
    .peak_sel(s_peak_sel), .q_empty(s_q_empty), .q_pop(s_q_pop),
    .setup_ph(s_setup_ph), .j(s_j), .draw_we(s_draw_we), .busy(s_busy),
    .done(s_done)
  );

  hough_seq_ctrl u_dflt (
    .clk(clk), .reset(reset), .start(d_start), .abort(d_abort),
    .pix_valid(d_pix_valid), .pix_ready(d_pix_ready), .pix_last(d_pix_last),
    .acc_clr(d_acc_clr), .vote_ph(d_vote_ph), .theta_base(d_theta_base),
    .lane_en(d_lane_en), .vote_we(d_vote_we), .q_push(d_q_push),
    .peak_sel(d_peak_sel), .q_empty(d_q_empty), .q_pop(d_q_pop),
    .setup_ph(d_setup_ph), .j(d_j), .draw_we(d_draw_we), .busy(d_busy),
    .done(d_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] s_outs();
    return 64'({s_pix_ready, s_acc_clr, s_vote_ph, s_theta_base, s_lane_en, s_vote_we,
                s_q_push, s_peak_sel, s_q_pop, s_setup_ph, s_j, s_draw_we, s_busy, s_done});
  endfunction

  function automatic logic [63:0] d_outs();
    return 64'({d_pix_ready, d_acc_clr, d_vote_ph, d_theta_base, d_lane_en, d_vote_we,
                d_q_push, d_peak_sel, d_q_pop, d_setup_ph, d_j, d_draw_we, d_busy, d_done});
  endfunction

  // Compare small-instance output events against the scoreboard queues.
  task automatic mon_small();
    vote_exp_t v;
    int        e;
    if (s_done) s_done_cnt++;
    if (s_vote_ph != 4'b0000) check("ready_in_vote", s_pix_ready, 1'b0);
    if (s_q_pop) begin
      check("pop_in_setup0", s_setup_ph, 3'b001);
      s_pops++;
    end
    if (s_vote_we) begin
      check("vote_we_phase", s_vote_ph, 4'b1000);
      if (vote_q.size() == 0) check("vote_unexpected", 1, 0);
      else begin
        v = vote_q.pop_front();
        check("vote_theta", s_theta_base, v.theta);
        check("vote_lane", s_lane_en, v.lane);
      end
    end
    if (s_q_push) begin
      if (push_q.size() == 0) check("push_unexpected", 1, 0);
      else begin
        e = push_q.pop_front();
        check("peak_sel", s_peak_sel, e);
      end
    end
    if (s_draw_we) begin
      if (draw_q.size() == 0) check("draw_unexpected", 1, 0);
      else begin
        e = draw_q.pop_front();
        check("draw_j", s_j, e);
      end
    end
  endtask

  // Sample at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_acc = s_pix_valid && s_pix_ready;
    d_acc = d_pix_valid && d_pix_ready;
    if (!reset) mon_small();
    @(posedge clk);
    #1;
  endtask

  // Expected groups for N_THETA=7, LANES=2.
  task automatic push_votes_small();
    logic [7:0] th [4];
    logic [1:0] ln [4];
    th = '{8'd0, 8'd2, 8'd4, 8'd6};
    ln = '{2'b11, 2'b11, 2'b11, 2'b01};
    for (int g = 0; g < 4; g++) vote_q.push_back('{theta: th[g], lane: ln[g]});
  endtask

  task automatic wait_accept_small(input string tag, output int waited);
    waited = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      waited++;
      if (s_acc) break;
    end
    check(tag, s_acc, 1'b1);
  endtask

  initial begin
    int gap;
    int vcyc, wcnt, pcnt, last_push, done_at;
    logic [7:0] last_theta;
    int done_before;

    reset = 1'b1;
    {s_start, s_abort, s_pix_valid, s_pix_last} = '0;
    {d_start, d_abort, d_pix_valid, d_pix_last} = '0;
    d_q_empty = 1'b1;
    tick();
    check("reset_hold_small", s_outs(), 64'd0);
    check("reset_hold_dflt", d_outs(), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_small", s_outs(), 64'd0);
    check("reset_dflt", d_outs(), 64'd0);

    // Frame 1: two pixels, valid held through the vote phases, one queue entry.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("acc_clr_pulse", s_acc_clr, 1'b1);
    check("ready_wait_pix", s_pix_ready, 1'b1);
    check("busy_after_start", s_busy, 1'b1);
    s_pix_valid = 1'b1;
    s_pix_last  = 1'b0;
    wait_accept_small("accept_pix0", gap);
    push_votes_small();
    check("acc_clr_one_cycle", s_acc_clr, 1'b0);
    s_pix_last = 1'b1;
    wait_accept_small("accept_pix1", gap);
    check("reaccept_gap", gap, 4 * ceil_div(7, 2) + 1);
    push_votes_small();
    s_pix_valid = 1'b0;
    s_pix_last  = 1'b0;
    push_q.push_back(0);
    push_q.push_back(1);
    s_loaded = 1;
    for (int k = 0; k < 4; k++) draw_q.push_back(k);
    for (int k = 0; k < 200; k++) begin
      tick();
      if (s_done) break;
    end
    check("done_seen", s_done, 1'b1);
    check("busy_at_done", s_busy, 1'b1);
    tick();
    check("done_one_cycle", s_done, 1'b0);
    check("busy_after_done", s_busy, 1'b0);
    check("vote_q_drained", vote_q.size(), 0);
    check("push_q_drained", push_q.size(), 0);
    check("draw_q_drained", draw_q.size(), 0);
    check("pops_frame1", s_pops, 1);

    // Frame 2: abort while in CALC.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_pix_valid = 1'b1;
    s_pix_last  = 1'b1;
    wait_accept_small("accept_f2", gap);
    push_votes_small();
    s_pix_valid = 1'b0;
    s_pix_last  = 1'b0;
    push_q.push_back(0);
    push_q.push_back(1);
    s_loaded = 2;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (s_setup_ph == 3'b100) break;
    end
    check("setup_last_phase", s_setup_ph, 3'b100);
    tick();
    check("calc_no_draw", {s_draw_we, s_setup_ph, s_busy}, {1'b0, 3'b000, 1'b1});
    done_before = s_done_cnt;
    s_abort = 1'b1;
    tick();
    s_abort = 1'b0;
    check("abort_outs", s_outs(), 64'd0);
    repeat (10) tick();
    check("abort_no_done", s_done_cnt, done_before);
    check("abort_stays_idle", s_busy, 1'b0);

    // Frame 3: synchronous reset during V2.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_pix_valid = 1'b1;
    s_pix_last  = 1'b1;
    wait_accept_small("accept_f3", gap);
    push_votes_small();
    s_pix_valid = 1'b0;
    s_pix_last  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (s_vote_ph == 4'b0100) break;
      tick();
    end
    check("in_v2", s_vote_ph, 4'b0100);
    done_before = s_done_cnt;
    reset = 1'b1;
    tick();
    check("reset_v2_outs", s_outs(), 64'd0);
    reset = 1'b0;
    vote_q.delete();
    tick();
    check("reset_v2_idle", s_outs(), 64'd0);
    repeat (10) tick();
    check("reset_no_done", s_done_cnt, done_before);

    // Default parameters: one last pixel, empty peak queue.
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    d_pix_valid = 1'b1;
    d_pix_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (d_acc) break;
    end
    check("d_accept", d_acc, 1'b1);
    d_pix_valid = 1'b0;
    d_pix_last  = 1'b0;
    vcyc = 0; wcnt = 0; pcnt = 0; last_push = -100; done_at = -1; last_theta = '0;
    for (int k = 0; k < 1000; k++) begin
      if (d_vote_ph != 4'b0000) vcyc++;
      if (d_vote_we) begin
        wcnt++;
        last_theta = d_theta_base;
        if (wcnt == 1) check("d_first_lane", d_lane_en, 2'b11);
      end
      if (d_q_push) begin
        check("d_peak_sel", d_peak_sel, pcnt);
        pcnt++;
        last_push = k;
      end
      if (d_done) begin
        done_at = k;
        break;
      end
      tick();
    end
    check("d_done_seen", d_done, 1'b1);
    check("d_vote_cycles", vcyc, 4 * ceil_div(180, 2));
    check("d_vote_groups", wcnt, ceil_div(180, 2));
    check("d_last_theta", last_theta, 8'd178);
    check("d_push_count", pcnt, 2);
    check("d_done_after_push", done_at - last_push, 2);
    check("d_busy_at_done", d_busy, 1'b1);
    tick();
    check("d_done_one_cycle", d_done, 1'b0);
    check("d_busy_after_done", d_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
